// File: rtl/sq_commit_unit.sv
// Store commit stage: computes the address, mask and data for the SQ head store and issues one dcache write at a time.
// Optional macro STORE_MISALIGN_TRAP_EN makes misaligned sh/sw stores trap instead of being force-aligned.
module sq_commit_unit #(
  parameter int ROB_IDX_W = 5,
  parameter int PHYS_W    = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sq_head_valid,
  input  logic [ROB_IDX_W-1:0] sq_rob_idx,
  input  logic [PHYS_W-1:0]    sq_rs1_paddr,
  input  logic [PHYS_W-1:0]    sq_rs2_paddr,
  input  logic [31:0]          sq_imm,
  input  logic [2:0]           sq_funct3,
  output logic                 sq_dequeue,
  input  logic                 rob_head_valid,
  input  logic [ROB_IDX_W-1:0] rob_head_idx,
  output logic [PHYS_W-1:0]    rf_rs1_paddr,
  output logic [PHYS_W-1:0]    rf_rs2_paddr,
  input  logic [31:0]          rf_rs1_data,
  input  logic [31:0]          rf_rs2_data,
  output logic [31:0]          dmem_addr,
  output logic [3:0]           dmem_wmask,
  output logic [31:0]          dmem_wdata,
  input  logic                 dmem_resp,
`ifdef STORE_MISALIGN_TRAP_EN
  output logic                 store_misalign,
`endif
  output logic                 store_done,
  output logic [ROB_IDX_W-1:0] store_done_rob_idx,
  output logic [31:0]          store_count
);

  typedef enum logic [1:0] {IDLE, REQ, TRAP} state_t;

  state_t state, state_nxt;

  logic [31:0]          ea_p0;
  logic                 match_p0;
  logic                 capture_p0;
  logic [31:0]          ea_p1;
  logic [2:0]           funct3_p1;
  logic [31:0]          rs2_p1;
  logic [ROB_IDX_W-1:0] rob_idx_p1;
  logic                 commit_p1;

  // Byte offset after forcing halfword/word stores onto their natural alignment.
  function automatic logic [1:0] aligned_off(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  return off;
      3'b001:  return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  return 4'b0001 << off;
      3'b001:  return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {4{d[7:0]}};
      3'b001:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  return 1'b0;
      3'b001:  return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  assign rf_rs1_paddr       = sq_rs1_paddr;
  assign rf_rs2_paddr       = sq_rs2_paddr;
  assign store_done_rob_idx = rob_idx_p1;

  always_comb begin
    ea_p0      = rf_rs1_data + sq_imm;
    match_p0   = sq_head_valid && rob_head_valid && (sq_rob_idx == rob_head_idx);
    capture_p0 = (state == IDLE) && match_p0;
  end

  // Stage p0 -> p1: capture the matched store's operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ea_p1       <= '0;
      funct3_p1   <= '0;
      rs2_p1      <= '0;
      rob_idx_p1  <= '0;
      store_count <= '0;
    end else begin
      state <= state_nxt;
      if (capture_p0) begin
        ea_p1      <= ea_p0;
        funct3_p1  <= sq_funct3;
        rs2_p1     <= rf_rs2_data;
        rob_idx_p1 <= sq_rob_idx;
      end
      if (commit_p1)
        store_count <= store_count + 32'd1;
    end
  end

  always_comb begin
    state_nxt  = state;
    commit_p1  = 1'b0;
    sq_dequeue = 1'b0;
    store_done = 1'b0;
    dmem_addr  = '0;
    dmem_wmask = '0;
    dmem_wdata = '0;
`ifdef STORE_MISALIGN_TRAP_EN
    store_misalign = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (match_p0) begin
`ifdef STORE_MISALIGN_TRAP_EN
          state_nxt = misaligned(sq_funct3, ea_p0[1:0]) ? TRAP : REQ;
`else
          state_nxt = REQ;
`endif
        end
      end
      REQ: begin
        dmem_addr  = {ea_p1[31:2], 2'b00};
        dmem_wmask = lane_mask(funct3_p1, aligned_off(funct3_p1, ea_p1[1:0]));
        dmem_wdata = lane_data(funct3_p1, rs2_p1);
        if (dmem_resp) begin
          commit_p1  = 1'b1;
          sq_dequeue = 1'b1;
          store_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
`ifdef STORE_MISALIGN_TRAP_EN
      TRAP: begin
        sq_dequeue     = 1'b1;
        store_done     = 1'b1;
        store_misalign = 1'b1;
        state_nxt      = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sq_commit_unit.sv
// Directed and randomized bench for sq_commit_unit with an arithmetic reference model of the store lanes.
module tb_sq_commit_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        sq_head_valid;
  logic [4:0]  sq_rob_idx;
  logic [5:0]  sq_rs1_paddr, sq_rs2_paddr;
  logic [31:0] sq_imm;
  logic [2:0]  sq_funct3;
  logic        sq_dequeue;
  logic        rob_head_valid;
  logic [4:0]  rob_head_idx;
  logic [5:0]  rf_rs1_paddr, rf_rs2_paddr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic        dmem_resp;
  logic        store_done;
  logic [4:0]  store_done_rob_idx;
  logic [31:0] store_count;
`ifdef STORE_MISALIGN_TRAP_EN
  logic        store_misalign;
`endif

  logic [31:0] rf [64];
  int vectors = 0;
  int miscompares = 0;
  int exp_count = 0;

  assign rf_rs1_data = rf[rf_rs1_paddr];
  assign rf_rs2_data = rf[rf_rs2_paddr];

  always #5 clk = ~clk;

  sq_commit_unit #(.ROB_IDX_W(5), .PHYS_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .sq_head_valid(sq_head_valid), .sq_rob_idx(sq_rob_idx),
    .sq_rs1_paddr(sq_rs1_paddr), .sq_rs2_paddr(sq_rs2_paddr),
    .sq_imm(sq_imm), .sq_funct3(sq_funct3), .sq_dequeue(sq_dequeue),
    .rob_head_valid(rob_head_valid), .rob_head_idx(rob_head_idx),
    .rf_rs1_paddr(rf_rs1_paddr), .rf_rs2_paddr(rf_rs2_paddr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .dmem_addr(dmem_addr), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_resp(dmem_resp),
`ifdef STORE_MISALIGN_TRAP_EN
    .store_misalign(store_misalign),
`endif
    .store_done(store_done), .store_done_rob_idx(store_done_rob_idx),
    .store_count(store_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: lanes from plain arithmetic on the byte offset.
  function automatic logic [3:0] ref_mask(input logic [2:0] f3, input logic [31:0] ea);
    int off = int'(ea % 4);
    if (f3 == 3'd0) return 4'(1 << off);
    if (f3 == 3'd1) return 4'(3 << ((off / 2) * 2));
    return 4'd15;
  endfunction

  function automatic logic [31:0] ref_data(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d & 32'hFF) * 32'h01010101;
    if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic bit ref_misal(input logic [2:0] f3, input logic [31:0] ea);
    if (f3 == 3'd0) return 1'b0;
    if (f3 == 3'd1) return (ea % 2) != 0;
    return (ea % 4) != 0;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_wmask"}, 32'(dmem_wmask), 32'h0);
    chk({tag, "_addr"}, dmem_addr, 32'h0);
    chk({tag, "_deq"}, 32'(sq_dequeue), 32'h0);
    chk({tag, "_done"}, 32'(store_done), 32'h0);
  endtask

  task automatic do_store(input logic [4:0] rob, input logic [31:0] base, input logic [31:0] imm,
                          input logic [31:0] d, input logic [2:0] f3, input int waits);
    logic [31:0] ea;
    logic [5:0]  p1, p2;
    ea = base + imm;
    p1 = 6'($urandom_range(1, 31));
    p2 = p1 + 6'd32;
    rf[p1] = base;
    rf[p2] = d;
    sq_head_valid = 1'b1; sq_rob_idx = rob; sq_rs1_paddr = p1; sq_rs2_paddr = p2;
    sq_imm = imm; sq_funct3 = f3; rob_head_valid = 1'b1; rob_head_idx = rob;
    #1;
    chk("rf_rs1_paddr", 32'(rf_rs1_paddr), 32'(p1));
    chk("idle_wmask", 32'(dmem_wmask), 32'h0);
    @(posedge clk); #1;
    // Inputs change during the request and must be ignored.
    sq_rob_idx = rob + 5'd1; sq_imm = $urandom; sq_funct3 = 3'($urandom);
    rf[p1] = $urandom; rf[p2] = $urandom;
    #1;
`ifdef STORE_MISALIGN_TRAP_EN
    if (ref_misal(f3, ea)) begin
      chk("trap_wmask", 32'(dmem_wmask), 32'h0);
      chk("trap_deq", 32'(sq_dequeue), 32'h1);
      chk("trap_done", 32'(store_done), 32'h1);
      chk("trap_misal", 32'(store_misalign), 32'h1);
      chk("trap_rob", 32'(store_done_rob_idx), 32'(rob));
      @(posedge clk); #1;
      sq_head_valid = 1'b0; #1;
      check_idle_outputs("post_trap");
      chk("trap_count", store_count, 32'(exp_count));
      return;
    end
`endif
    for (int i = 0; i < waits; i++) begin
      chk("hold_addr", dmem_addr, {ea[31:2], 2'b00});
      chk("hold_wmask", 32'(dmem_wmask), 32'(ref_mask(f3, ea)));
      chk("hold_wdata", dmem_wdata, ref_data(f3, d));
      chk("hold_deq", 32'(sq_dequeue), 32'h0);
      chk("hold_done", 32'(store_done), 32'h0);
      @(posedge clk); #2;
    end
    dmem_resp = 1'b1; #1;
    chk("resp_addr", dmem_addr, {ea[31:2], 2'b00});
    chk("resp_wmask", 32'(dmem_wmask), 32'(ref_mask(f3, ea)));
    chk("resp_wdata", dmem_wdata, ref_data(f3, d));
    chk("resp_deq", 32'(sq_dequeue), 32'h1);
    chk("resp_done", 32'(store_done), 32'h1);
    chk("resp_rob", 32'(store_done_rob_idx), 32'(rob));
    exp_count++;
    @(posedge clk); #1;
    dmem_resp = 1'b0; sq_head_valid = 1'b0; #1;
    check_idle_outputs("post_resp");
    chk("count", store_count, 32'(exp_count));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rf[i] = 32'h0;
    rst_n = 1'b0; sq_head_valid = 1'b0; sq_rob_idx = '0; sq_rs1_paddr = '0; sq_rs2_paddr = '0;
    sq_imm = '0; sq_funct3 = '0; rob_head_valid = 1'b0; rob_head_idx = '0; dmem_resp = 1'b0;
    #2;
    check_idle_outputs("reset");
    chk("reset_count", store_count, 32'h0);
    chk("reset_rob", 32'(store_done_rob_idx), 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_store(5'd1, 32'h1000, 32'h4, 32'hDEADBEEF, 3'd2, 3);
    do_store(5'd2, 32'h2000, 32'h3, 32'h000000A5, 3'd0, 1);
    do_store(5'd3, 32'h2000, 32'h2, 32'h00001234, 3'd1, 0);
    do_store(5'd4, 32'h1000, 32'h2, 32'hCAFEF00D, 3'd2, 1);

    // ROB head mismatch holds off the request
    rf[5] = 32'h3000; rf[6] = 32'h11223344;
    sq_head_valid = 1'b1; sq_rob_idx = 5'd3; sq_rs1_paddr = 6'd5; sq_rs2_paddr = 6'd6;
    sq_imm = 32'h8; sq_funct3 = 3'd2; rob_head_valid = 1'b1; rob_head_idx = 5'd2;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      chk("nomatch_wmask", 32'(dmem_wmask), 32'h0);
    end
    rob_head_idx = 5'd3;
    @(posedge clk); #2;
    chk("late_addr", dmem_addr, 32'h3008);
    chk("late_wmask", 32'(dmem_wmask), 32'hF);
    dmem_resp = 1'b1; #1;
    chk("late_done", 32'(store_done), 32'h1);
    exp_count++;
    @(posedge clk); #1; dmem_resp = 1'b0; sq_head_valid = 1'b0; #1;
    chk("late_count", store_count, 32'(exp_count));

    // Response while idle is ignored
    dmem_resp = 1'b1; #1;
    check_idle_outputs("idle_resp");
    @(posedge clk); #1; dmem_resp = 1'b0; #1;
    chk("idle_resp_count", store_count, 32'(exp_count));

    // Back-to-back zero-wait stores
    do_store(5'd7, 32'h4000, 32'h10, 32'h0BADF00D, 3'd2, 0);
    do_store(5'd8, 32'h4000, 32'h15, 32'h000000EE, 3'd0, 0);

    // Randomized stores
    for (int n = 0; n < 24; n++) begin
      logic [2:0] f3;
      f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      do_store(5'($urandom), $urandom, 32'($urandom_range(0, 255)) - 32'd128, $urandom, f3,
               int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a request aborts it
    rf[9] = 32'h5000; rf[10] = 32'h55AA55AA;
    sq_head_valid = 1'b1; sq_rob_idx = 5'd9; sq_rs1_paddr = 6'd9; sq_rs2_paddr = 6'd10;
    sq_imm = 32'h0; sq_funct3 = 3'd2; rob_head_valid = 1'b1; rob_head_idx = 5'd9;
    @(posedge clk); #1; sq_head_valid = 1'b0; #1;
    chk("abort_pre_wmask", 32'(dmem_wmask), 32'hF);
    rst_n = 1'b0; dmem_resp = 1'b1; #1;
    check_idle_outputs("abort");
    chk("abort_count", store_count, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1; dmem_resp = 1'b0;
    @(posedge clk); #2;
    check_idle_outputs("after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
